pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Arbitrates per-stage stall requests into per-register enable/bubble controls for the pc, if_id, id_ex, ex_mem and mem_wb registers. Converts a MEM-stage exception or ERET into a pipeline flush plus a PC redirect. A redirect that collides with a fetch stall is held pending until fetch can accept it.

Parameters:
EXC_VECTOR, 32'hBFC00380, general exception entry PC
ERET_CODE, 32'h0000000E, except_type value meaning ERET
PC_W, 32, PC width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (0 = reset asserted)
stallreq_if  in  1  fetch/icache not ready
stallreq_id  in  1  load-use interlock
stallreq_ex  in  1  multi-cycle ALU (madd/msub/div) busy
stallreq_mem  in  1  dcache/bus not ready
mem_except_type  in  32  from MEM stage after CP0 resolution; 0 = none
cp0_epc  in  PC_W  EPC for ERET
en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1 each  register advance enables
bub_if_id, bub_id_ex, bub_ex_mem, bub_mem_wb  out  1 each  load NOP into register at next edge
flush  out  1  clear if_id/id_ex/ex_mem (drives their flush inputs)
redirect  out  1  pc loads redirect_pc at next edge
redirect_pc  out  PC_W  target PC
stall_cycles  out  32  count of cycles with any stall asserted, wraps
flush_count  out  32  count of accepted exceptions/ERETs, wraps

Behaviour:
- Reset (rst=0, async): FSM=RUN, pend_pc=0, counters=0. All en_*=1, bub_*=0, flush=0, redirect=0, redirect_pc=0.
- Stall arbitration (combinational, RUN state, no exception): the most-downstream request wins.
  - stallreq_mem: en_pc..en_ex_mem=0, bub_mem_wb=1.
  - else stallreq_ex: en_pc..en_id_ex=0, bub_ex_mem=1.
  - else stallreq_id: en_pc, en_if_id=0, bub_id_ex=1.
  - else stallreq_if: en_pc=0, bub_if_id=1.
  - Any register not named stays enabled.
- Exception accept: condition is mem_except_type!=0 && !stallreq_mem, in RUN or PEND. The same cycle (0 latency):
  - flush=1; bub_* and en_* are ignored by the flushed registers.
  - en_mem_wb=1; the MEM stage has already suppressed writes.
  - flush_count++.
  - Target = cp0_epc if mem_except_type==ERET_CODE, else EXC_VECTOR.
  - If !stallreq_if: redirect=1, redirect_pc=target, en_pc=1; FSM stays RUN.
  - If stallreq_if: pend_pc<=target, FSM->PEND, redirect=0.
- With stallreq_mem=1 and a pending exception: no flush, normal stall; the exception is re-evaluated next cycle.
- PEND state:
  - Each cycle: bub_if_id=1, en_pc=0, redirect_pc=pend_pc.
  - When stallreq_if falls: redirect=1, en_pc=1, FSM->RUN.
  - A new exception accepted in PEND overwrites pend_pc (latest wins). If stallreq_if is also low that cycle, redirect to the new target directly.
  - Downstream stall arbitration continues normally in PEND.
- stall_cycles increments when any stallreq_* =1 or FSM==PEND. It does not increment during an exception-accept cycle with RUN->RUN.
- Counters wrap at 2^32. Reset mid-PEND discards pend_pc.
- Outputs are combinational from FSM state and inputs. Only FSM, pend_pc and counters are registered.

Decomposition:
- Shared package entries: FSM enum {RUN, PEND}; constants EXC_VECTOR_DEFAULT and ERET_CODE (joining the existing except_type codes); a stall_vec_t struct grouping en/bub per register.
- One natural sub-module: stall_arbiter, a pure combinational priority encoder from stallreq_* to en/bub. pipe_ctrl instantiates it and overrides its outputs on flush and PEND.

Test Plan:
1. Reset then idle with no requests -> all en=1, bub=0, flush=0, redirect=0; counters stay 0 for 10 cycles.
2. stallreq_id=1 and stallreq_ex=1 for 3 cycles -> en_pc=en_if_id=en_id_ex=0, bub_ex_mem=1, bub_id_ex=0; stall_cycles=3.
3. mem_except_type=32'h1, stallreq_if=0 -> same cycle flush=1, redirect=1, redirect_pc=32'hBFC00380; flush_count=1.
4. mem_except_type=ERET_CODE, cp0_epc=32'h80001234, stallreq_if=1 for 4 cycles -> redirect=0 and bub_if_id=1 for 4 cycles. Then redirect=1 with redirect_pc=32'h80001234 in the cycle stallreq_if falls, then RUN.
5. Exception together with stallreq_mem=1 for 2 cycles -> flush=0, bub_mem_wb=1 for 2 cycles. Flush occurs in the third cycle when stallreq_mem drops.
6. rst pulsed low mid-PEND -> redirect never asserted; after release state is RUN and counters are 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM states, exception codes and per-register stall controls.
package pipe_ctrl_pkg;

    typedef enum logic {RUN, PEND} state_t;

    localparam logic [31:0] EXC_NONE           = 32'h0000_0000;
    localparam logic [31:0] ERET_CODE          = 32'h0000_000E;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef struct packed {
        logic en_pc;
        logic en_if_id;
        logic en_id_ex;
        logic en_ex_mem;
        logic en_mem_wb;
        logic bub_if_id;
        logic bub_id_ex;
        logic bub_ex_mem;
        logic bub_mem_wb;
    } stall_vec_t;

    localparam stall_vec_t STALL_NONE = '{
        en_pc: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1, en_ex_mem: 1'b1, en_mem_wb: 1'b1,
        bub_if_id: 1'b0, bub_id_ex: 1'b0, bub_ex_mem: 1'b0, bub_mem_wb: 1'b0
    };

endpackage

// File: rtl/pipe_ctrl_stall_arbiter.sv
// stall_arbiter: priority encoder from stage stall requests to register enables/bubbles.
module stall_arbiter
    import pipe_ctrl_pkg::*;
(
    input  logic       stallreq_if,
    input  logic       stallreq_id,
    input  logic       stallreq_ex,
    input  logic       stallreq_mem,
    output stall_vec_t sv
);

    // The most-downstream request freezes everything upstream of it.
    always_comb begin
        sv = STALL_NONE;
        if (stallreq_mem) begin
            sv.en_pc      = 1'b0;
            sv.en_if_id   = 1'b0;
            sv.en_id_ex   = 1'b0;
            sv.en_ex_mem  = 1'b0;
            sv.bub_mem_wb = 1'b1;
        end else if (stallreq_ex) begin
            sv.en_pc      = 1'b0;
            sv.en_if_id   = 1'b0;
            sv.en_id_ex   = 1'b0;
            sv.bub_ex_mem = 1'b1;
        end else if (stallreq_id) begin
            sv.en_pc     = 1'b0;
            sv.en_if_id  = 1'b0;
            sv.bub_id_ex = 1'b1;
        end else if (stallreq_if) begin
            sv.en_pc     = 1'b0;
            sv.bub_if_id = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush sequencer with exception/ERET redirect and
// a pending redirect held while fetch is stalled.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] ERET_CODE  = pipe_ctrl_pkg::ERET_CODE,
    parameter int          PC_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallreq_if,
    input  logic            stallreq_id,
    input  logic            stallreq_ex,
    input  logic            stallreq_mem,
    input  logic [31:0]     mem_except_type,
    input  logic [PC_W-1:0] cp0_epc,
    output logic            en_pc,
    output logic            en_if_id,
    output logic            en_id_ex,
    output logic            en_ex_mem,
    output logic            en_mem_wb,
    output logic            bub_if_id,
    output logic            bub_id_ex,
    output logic            bub_ex_mem,
    output logic            bub_mem_wb,
    output logic            flush,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
);
    import pipe_ctrl_pkg::*;

    state_t          state, state_nx;
    logic [PC_W-1:0] pend_pc, target;
    logic            accept, stall_inc;
    stall_vec_t      arb, ctl;

    stall_arbiter u_arb (
        .stallreq_if (stallreq_if),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .sv          (arb)
    );

    assign accept    = (mem_except_type != EXC_NONE) && !stallreq_mem;
    assign target    = (mem_except_type == ERET_CODE) ? cp0_epc : PC_W'(EXC_VECTOR);
    // An accept that redirects straight from RUN is a flush, not a stall.
    assign stall_inc = (stallreq_if || stallreq_id || stallreq_ex || stallreq_mem || state == PEND)
                       && !(accept && state == RUN && !stallreq_if);

    always_comb begin
        ctl         = arb;
        state_nx    = state;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        if (state == PEND) begin
            ctl.bub_if_id = 1'b1;
            ctl.en_pc     = !stallreq_if;
            redirect      = !stallreq_if;
            redirect_pc   = pend_pc;
            state_nx      = stallreq_if ? PEND : RUN;
        end
        if (accept) begin
            flush         = 1'b1;
            ctl.en_mem_wb = 1'b1;
            ctl.en_pc     = !stallreq_if;
            redirect      = !stallreq_if;
            redirect_pc   = stallreq_if ? redirect_pc : target;
            state_nx      = stallreq_if ? PEND : RUN;
        end
    end

    assign en_pc      = ctl.en_pc;
    assign en_if_id   = ctl.en_if_id;
    assign en_id_ex   = ctl.en_id_ex;
    assign en_ex_mem  = ctl.en_ex_mem;
    assign en_mem_wb  = ctl.en_mem_wb;
    assign bub_if_id  = ctl.bub_if_id;
    assign bub_id_ex  = ctl.bub_id_ex;
    assign bub_ex_mem = ctl.bub_ex_mem;
    assign bub_mem_wb = ctl.bub_mem_wb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            pend_pc      <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state        <= state_nx;
            pend_pc      <= (accept && stallreq_if) ? target : pend_pc;
            stall_cycles <= stall_cycles + 32'(stall_inc);
            flush_count  <= flush_count + 32'(accept);
        end
    end

endmodule
